// File: rtl/cla_pkg.sv
// Shared constants, types and the in-group carry lookahead for the 16-bit pipelined CLA.
// Optional flag logic is controlled by the CLA16_FLAGS_EN macro in cla16_pipe_adder.sv.
package cla_pkg;

    localparam int DATA_W = 16;
    localparam int GRP_W  = 4;
    localparam int N_GRP  = 4;

    typedef struct packed {
        logic [GRP_W-1:0] p;
        logic [GRP_W-1:0] g;
    } pg_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic [DATA_W-1:0] p;
        logic [DATA_W-1:0] g;
        logic [N_GRP-1:0]  gp;
        logic [N_GRP-1:0]  gg;
    } stage1_t;

    // Carry into each bit of a group, flat two-level form from the group carry-in.
    function automatic logic [GRP_W-1:0] grp_carries(input pg_t pg, input logic ci);
        logic [GRP_W-1:0] c;
        c[0] = ci;
        c[1] = pg.g[0] | (pg.p[0] & ci);
        c[2] = pg.g[1] | (pg.p[1] & pg.g[0]) | (pg.p[1] & pg.p[0] & ci);
        c[3] = pg.g[2] | (pg.p[2] & pg.g[1]) | (pg.p[2] & pg.p[1] & pg.g[0])
             | (pg.p[2] & pg.p[1] & pg.p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/cla16_pipe_adder_if.sv
// Operand/result handshake bundle for cla16_pipe_adder.
// The adder takes the slave modport; the operand source/result sink takes master.
interface cla16_pipe_adder_if;
    import cla_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
    logic              zero;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/cla_group_pg4.sv
// 4-bit group propagate/generate: group propagates when all bits propagate,
// group generates when some bit generates and every higher bit propagates it.
module cla_group_pg4
    import cla_pkg::*;
(
    input  pg_t  pg,
    output logic gp,
    output logic gg
);

    assign gp = &pg.p;
    assign gg = pg.g[3]
              | (pg.p[3] & pg.g[2])
              | (pg.p[3] & pg.p[2] & pg.g[1])
              | (pg.p[3] & pg.p[2] & pg.p[1] & pg.g[0]);

endmodule

// File: rtl/cla16_pipe_adder.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both sides.
// Define CLA16_FLAGS_EN to compute ovf/zero; otherwise those outputs are tied to 0.
module cla16_pipe_adder
    import cla_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    cla16_pipe_adder_if.slave  bus
);

    // Handshake: a beat transfers on a rising edge where valid && ready are both high.
    // Ready never looks at valid, and a producer holds its data steady until it transfers.
    logic              s1_valid;
    logic              out_valid_q;
    logic              advance;
    logic              accept;
    stage1_t           s1_d;
    stage1_t           s1_q;
    logic [DATA_W-1:0] p_d;
    logic [DATA_W-1:0] g_d;
    logic [N_GRP-1:0]  gp_d;
    logic [N_GRP-1:0]  gg_d;

    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = rst_n && (!s1_valid || advance);
    assign accept       = bus.in_valid && bus.in_ready;

    // Stage 1: bit and group propagate/generate terms
    assign p_d = bus.a ^ bus.b;
    assign g_d = bus.a & bus.b;

    for (genvar k = 0; k < N_GRP; k++) begin : g_grp
        pg_t grp_pg;
        assign grp_pg.p = p_d[k*GRP_W +: GRP_W];
        assign grp_pg.g = g_d[k*GRP_W +: GRP_W];
        cla_group_pg4 u_pg (
            .pg (grp_pg),
            .gp (gp_d[k]),
            .gg (gg_d[k])
        );
    end

    assign s1_d = '{a: bus.a, b: bus.b, cin: bus.cin, p: p_d, g: g_d, gp: gp_d, gg: gg_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (accept) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage 2: group carries, all taken straight from stage-1 terms and cin (no ripple)
    logic [N_GRP:0]    grp_c;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] sum_d;
    pg_t               pg_sel;

    assign grp_c[0] = s1_q.cin;
    assign grp_c[1] = s1_q.gg[0] | (s1_q.gp[0] & s1_q.cin);
    assign grp_c[2] = s1_q.gg[1] | (s1_q.gp[1] & s1_q.gg[0])
                    | (s1_q.gp[1] & s1_q.gp[0] & s1_q.cin);
    assign grp_c[3] = s1_q.gg[2] | (s1_q.gp[2] & s1_q.gg[1])
                    | (s1_q.gp[2] & s1_q.gp[1] & s1_q.gg[0])
                    | (s1_q.gp[2] & s1_q.gp[1] & s1_q.gp[0] & s1_q.cin);
    assign grp_c[4] = s1_q.gg[3] | (s1_q.gp[3] & s1_q.gg[2])
                    | (s1_q.gp[3] & s1_q.gp[2] & s1_q.gg[1])
                    | (s1_q.gp[3] & s1_q.gp[2] & s1_q.gp[1] & s1_q.gg[0])
                    | (s1_q.gp[3] & s1_q.gp[2] & s1_q.gp[1] & s1_q.gp[0] & s1_q.cin);

    always_comb begin
        c      = '0;
        pg_sel = '0;
        for (int k = 0; k < N_GRP; k++) begin
            pg_sel.p = s1_q.p[k*GRP_W +: GRP_W];
            pg_sel.g = s1_q.g[k*GRP_W +: GRP_W];
            c[k*GRP_W +: GRP_W] = grp_carries(pg_sel, grp_c[k]);
        end
    end

    assign sum_d = s1_q.p ^ c;

    logic [DATA_W-1:0] sum_q;
    logic              cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_d;
                cout_q <= grp_c[N_GRP];
            end
        end
    end

`ifdef CLA16_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance && s1_valid) begin
            ovf_q  <= c[DATA_W-1] ^ grp_c[N_GRP];
            zero_q <= (sum_d == '0);
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cla16_pipe_adder.sv
// Scoreboard bench for cla16_pipe_adder: accepted beats push a+b+cin results, a monitor
// compares the head of the queue whenever out_valid is high and pops on out_ready.
module tb_cla16_pipe_adder;
  import cla_pkg::*;

  localparam int W = 19;  // {zero, ovf, cout, sum}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla16_pipe_adder_if bus ();

  cla16_pipe_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int run_len = 0;
  int max_run = 0;
  bit stress_done = 1'b0;

  function automatic logic [W-1:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int unsigned full;
    logic [15:0] s;
    logic co, ov, zr;
    full = int'(a) + int'(b) + int'(cin);
    s = full[15:0];
    co = full[16];
`ifdef CLA16_FLAGS_EN
    ov = (a[15] == b[15]) && (s[15] != a[15]);
    zr = (full[15:0] == 16'd0);
`else
    ov = 1'b0;
    zr = 1'b0;
`endif
    return {zr, ov, co, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got sum %h with no beat outstanding", bus.sum);
        end else begin
          check("result", {13'd0, bus.zero, bus.ovf, bus.cout, bus.sum}, {13'd0, exp_q[0]});
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end else begin
        run_len = 0;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin));
        acc_cnt++;
      end
    end
  end

  // Driver: call between a rising edge and the next falling edge; returns just after the transfer edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: in_ready stuck at %b, required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int base_acc;
    int base_out;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Basic beat and latency
    drive(16'h1234, 16'h4321, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("latency_one_edge", bus.out_valid, 0);
    @(negedge clk);
    #1;
    check("latency_two_edges", bus.out_valid, 1);
    check("basic_sum", bus.sum, 32'h5555);
    drain();

    // Directed corner cases: wrap, signed overflow, full lookahead chain
    @(posedge clk);
    #1;
    drive(16'hFFFF, 16'h0001, 1'b0);
    drive(16'h7FFF, 16'h0001, 1'b0);
    drive(16'hFFFF, 16'h0000, 1'b1);
    drive(16'h8000, 16'h8000, 1'b0);
    drive(16'h0000, 16'h0000, 1'b0);
    bus.in_valid = 1'b0;
    drain();

    // Back-pressure: out_ready low for 3 cycles while streaming 4 beats
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    base_acc = acc_cnt;
    base_out = out_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++) drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        bus.in_valid = 1'b0;
      end
    join_none
    repeat (3) @(negedge clk);
    #1;
    check("bp_accepts", acc_cnt - base_acc, 2);
    check("bp_in_ready", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait fork;
    drain();
    check("bp_out_count", out_cnt - base_out, 4);

    // Throughput: 16 back-to-back beats
    @(posedge clk);
    #1;
    max_run = 0;
    base_out = out_cnt;
    for (int i = 0; i < 16; i++) drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    bus.in_valid = 1'b0;
    drain();
    check("tput_run", max_run, 16);
    check("tput_count", out_cnt - base_out, 16);

    // Random stress with random out_ready and input gaps
    base_acc = acc_cnt;
    base_out = out_cnt;
    fork
      begin
        while (!stress_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          drive(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
        stress_done = 1'b1;
      end
    join
    drain();
    check("stress_count", out_cnt - base_out, acc_cnt - base_acc);

    // Reset with two beats in flight
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive(16'hA5A5, 16'h1111, 1'b1);
    drive(16'h0F0F, 16'hF0F0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("no_stale_out_valid", bus.out_valid, 0);
    check("post_midrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
